mhp_frame_tx: RTL

Parametrised MHP frame serializer, successor to the fixed-length frame assembler.
- Captures header fields and a variable-length payload on `start`.
- Emits the frame one byte per handshake on a valid/ready byte stream.
- Computes the frame checksum (SCS) internally while sending, then appends it.
- Sits between the protocol controller (field producer) and the byte-level TX link (UART/FIFO writer).

---
 rtl/mhp_pkg.sv | 17 +
 rtl/mhp_scs_accum.sv | 25 ++
 rtl/mhp_frame_tx.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mhp_pkg.sv
// Shared MHP framing definitions: lengths, TX state encoding and the SCS term weighting.
package mhp_pkg;

    localparam int HDR_LEN = 7;
    localparam int SCS_LEN = 2;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

    // Each checksummed byte is weighted by a left shift of (byte position mod 4).
    function automatic logic [15:0] scs_term(input logic [7:0] data_byte, input logic [1:0] index);
        return {8'h00, data_byte} << index;
    endfunction

endpackage

// File: rtl/mhp_scs_accum.sv
// Running MHP frame checksum; next_sum exposes the sum including the byte on the inputs.
module mhp_scs_accum
    import mhp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        enable,
    input  logic [7:0]  data_byte,
    input  logic [1:0]  index,
    output logic [15:0] sum,
    output logic [15:0] next_sum
);

    assign next_sum = sum + scs_term(data_byte, index);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sum <= '0;
        end else if (enable) begin
            sum <= next_sum;
        end
    end

endmodule

// File: rtl/mhp_frame_tx.sv
// MHP frame serializer: captures header and payload on start, streams them byte-wise, appends SCS.
//   state | meaning
//   IDLE  | waiting for start, outputs quiet
//   SEND  | presenting byte idx of the captured frame on the stream
module mhp_frame_tx
    import mhp_pkg::*;
#(
    parameter int MAX_PAYLOAD = 42,
    parameter int PLEN_W      = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [15:0]              i_dst,
    input  logic [15:0]              i_src,
    input  logic [15:0]              i_size,
    input  logic                     i_dir,
    input  logic [6:0]               i_type,
    input  logic [MAX_PAYLOAD*8-1:0] i_payload,
    input  logic [PLEN_W-1:0]        i_payload_size,
    output logic [7:0]               o_wdata,
    output logic                     o_wvalid,
    input  logic                     i_wready,
    output logic                     busy,
    output logic                     done
);

    localparam int CNT_W = $clog2(MAX_PAYLOAD + HDR_LEN + SCS_LEN + 1);
    localparam logic [PLEN_W-1:0] MAX_N = PLEN_W'(MAX_PAYLOAD);

    tx_state_t                state;
    logic [15:0]              dst_q;
    logic [15:0]              src_q;
    logic [15:0]              size_q;
    logic [7:0]               dirtype_q;
    logic [MAX_PAYLOAD*8-1:0] payload_q;
    logic [CNT_W-1:0]         n_q;
    logic [CNT_W-1:0]         idx;

    logic [CNT_W-1:0] nxt_idx;
    logic [CNT_W-1:0] scs_lo_idx;
    logic [CNT_W-1:0] scs_hi_idx;
    logic [CNT_W-1:0] pl_idx;
    logic             accept;
    logic             scs_clear;
    logic             scs_en;
    logic [15:0]      scs_sum;
    logic [15:0]      scs_next;
    logic [7:0]       data_nxt;
    logic [7:0]       scs_byte;

    assign accept     = (state == SEND) && o_wvalid && i_wready;
    assign nxt_idx    = idx + CNT_W'(1);
    assign scs_lo_idx = n_q + CNT_W'(HDR_LEN);
    assign scs_hi_idx = scs_lo_idx + CNT_W'(1);
    assign pl_idx     = nxt_idx - CNT_W'(HDR_LEN);
    assign scs_clear  = (state == IDLE) && start;
    assign scs_en     = accept && (idx < scs_lo_idx);

    // Low SCS byte must already include the byte being accepted, hence next_sum.
    assign scs_byte = (nxt_idx == scs_lo_idx) ? 8'(scs_next) : 8'(scs_sum >> 8);

    mhp_scs_accum u_scs (
        .clk       (clk),
        .rst       (rst),
        .clear     (scs_clear),
        .enable    (scs_en),
        .data_byte (o_wdata),
        .index     (idx[1:0]),
        .sum       (scs_sum),
        .next_sum  (scs_next)
    );

    always_comb begin
        data_nxt = 8'(payload_q >> {pl_idx, 3'b000});
        case (nxt_idx)
            CNT_W'(1): data_nxt = dst_q[15:8];
            CNT_W'(2): data_nxt = src_q[7:0];
            CNT_W'(3): data_nxt = src_q[15:8];
            CNT_W'(4): data_nxt = size_q[7:0];
            CNT_W'(5): data_nxt = size_q[15:8];
            CNT_W'(6): data_nxt = dirtype_q;
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            o_wvalid  <= 1'b0;
            o_wdata   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            idx       <= '0;
            n_q       <= '0;
            dst_q     <= '0;
            src_q     <= '0;
            size_q    <= '0;
            dirtype_q <= '0;
            payload_q <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dst_q     <= i_dst;
                        src_q     <= i_src;
                        size_q    <= i_size;
                        dirtype_q <= {i_dir, i_type};
                        payload_q <= i_payload;
                        n_q       <= CNT_W'((i_payload_size > MAX_N) ? MAX_N : i_payload_size);
                        idx       <= '0;
                        o_wdata   <= i_dst[7:0];
                        o_wvalid  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (accept) begin
                        if (idx == scs_hi_idx) begin
                            o_wvalid <= 1'b0;
                            o_wdata  <= '0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            idx      <= '0;
                            state    <= IDLE;
                        end else begin
                            idx <= nxt_idx;
                            if (nxt_idx >= scs_lo_idx) begin
                                o_wdata <= scs_byte;
                            end else begin
                                o_wdata <= data_nxt;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
